// File: rtl/btn_press_classifier_if.sv
// rtl/btn_press_classifier_if.sv - button edge in / gesture pulse out bundle
//
// Groups the debounced edge pulses with the classified gesture pulses.
//   master : the edge detector / consumer side (drives edges, reads gestures)
//   slave  : the classifier (reads edges, drives gestures)
// Signals:
//   btn_pedge     1-cycle pulse, debounced button pressed
//   btn_nedge     1-cycle pulse, debounced button released
//   short_press   1-cycle pulse, single short click confirmed
//   double_click  1-cycle pulse, second click released
//   long_press    1-cycle pulse, hold reached the long-press threshold
//   repeat_tick   1-cycle pulse, auto-repeat while long-held
//   busy          level, classifier is mid-gesture
interface btn_press_classifier_if;
   logic btn_pedge;
   logic btn_nedge;
   logic short_press;
   logic double_click;
   logic long_press;
   logic repeat_tick;
   logic busy;

   modport master (
      output btn_pedge,
      output btn_nedge,
      input  short_press,
      input  double_click,
      input  long_press,
      input  repeat_tick,
      input  busy
   );

   modport slave (
      input  btn_pedge,
      input  btn_nedge,
      output short_press,
      output double_click,
      output long_press,
      output repeat_tick,
      output busy
   );
endinterface

// File: rtl/btn_press_classifier.sv
// rtl/btn_press_classifier.sv - classify button gestures into short/double/long/repeat pulses
//
// Consumes single-cycle press/release pulses from a debounced button stage and
// classifies each gesture as a short press, a double click or a long press,
// emitting auto-repeat ticks while a long press is held. One instance per button.
// Ports:
//   clk      in  system clock, rising edge
//   reset_p  in  asynchronous active-high reset (assert async, release synced to clk)
//   bus      slave modport of btn_press_classifier_if (edges in, gesture pulses out)
// Parameters:
//   LONG_CYCLES    hold time that qualifies a long press
//   DCLICK_CYCLES  max release gap before a second press counts as a double click
//   REPEAT_CYCLES  auto-repeat period while long-held
//   CNT_W          counter width, must hold max(parameter)-1
module btn_press_classifier #(
   parameter int LONG_CYCLES   = 100_000_000,
   parameter int DCLICK_CYCLES = 30_000_000,
   parameter int REPEAT_CYCLES = 20_000_000,
   parameter int CNT_W         = 27
) (
   input  logic                  clk,
   input  logic                  reset_p,
   btn_press_classifier_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      WAIT2     = 3'd2,
      PRESS2    = 3'd3,
      LONG_HELD = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   // Reset asserts asynchronously through the set path of this pair and
   // releases two clock edges after reset_p drops, so every flop leaves
   // reset on the same edge.
   logic [1:0] rst_sync;
   logic       rst_int;

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         rst_sync <= 2'b11;
      end else begin
         rst_sync <= {rst_sync[0], 1'b0};
      end
   end

   assign rst_int = rst_sync[1];

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic             cnt_clr;
   logic             cnt_run;

   logic short_d, double_d, long_d, repeat_d;
   logic short_q, double_q, long_q, repeat_q, busy_q;

   // Simultaneous press and release cancel each other out.
   logic ev_press;
   logic ev_release;

   assign ev_press   = bus.btn_pedge & ~bus.btn_nedge;
   assign ev_release = bus.btn_nedge & ~bus.btn_pedge;

   // Edges are tested before timeouts in every state, so an edge wins when
   // both land on the same cycle.
   always_comb begin
      state_nx = state;
      cnt_clr  = 1'b0;
      cnt_run  = 1'b0;
      short_d  = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
      repeat_d = 1'b0;

      case (state)
         IDLE: begin
            if (ev_press) begin
               state_nx = PRESS1;
            end
         end

         PRESS1: begin
            cnt_run = 1'b1;
            if (ev_release) begin
               state_nx = WAIT2;
            end else if (cnt == LONG_LAST) begin
               state_nx = LONG_HELD;
               long_d   = 1'b1;
            end
         end

         WAIT2: begin
            cnt_run = 1'b1;
            if (ev_press) begin
               state_nx = PRESS2;
            end else if (cnt == DCLICK_LAST) begin
               state_nx = IDLE;
               short_d  = 1'b1;
            end
         end

         PRESS2: begin
            // Second hold has no timeout, so the counter stays parked at 0.
            if (ev_release) begin
               state_nx = IDLE;
               double_d = 1'b1;
            end
         end

         LONG_HELD: begin
            cnt_run = 1'b1;
            if (ev_release) begin
               state_nx = IDLE;
            end else if (cnt == REPEAT_LAST) begin
               repeat_d = 1'b1;
               cnt_clr  = 1'b1;
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Counter only runs in states that have a timeout; everywhere else it is
   // held at 0 so it can never wrap.
   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         cnt <= '0;
      end else if ((state_nx != state) || cnt_clr || !cnt_run) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         short_q  <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
         repeat_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         short_q  <= short_d;
         double_q <= double_d;
         long_q   <= long_d;
         repeat_q <= repeat_d;
         busy_q   <= (state_nx != IDLE);
      end
   end

   assign bus.short_press  = short_q;
   assign bus.double_click = double_q;
   assign bus.long_press   = long_q;
   assign bus.repeat_tick  = repeat_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_btn_press_classifier.sv
// tb/tb_btn_press_classifier.sv - directed self-checking bench for btn_press_classifier
module tb_btn_press_classifier;

   logic clk;
   logic reset_p;
   int   n_cmp;
   int   n_bad;

   btn_press_classifier_if bif ();

   btn_press_classifier #(
      .LONG_CYCLES   (20),
      .DCLICK_CYCLES (8),
      .REPEAT_CYCLES (5),
      .CNT_W         (5)
   ) dut (
      .clk     (clk),
      .reset_p (reset_p),
      .bus     (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] outs();
      return {3'b000, bif.short_press, bif.double_click, bif.long_press,
              bif.repeat_tick, bif.busy};
   endfunction

   // Cycle c: outputs sampled just after its opening edge, then the inputs
   // for cycle c are applied. A pulse listed at time t is expected in cycle t.
   // -1 means "never"; busy is expected high for cycles bf <= c < bt.
   task automatic run_scn(input int id, input int p0, input int p1,
                          input int n0, input int n1,
                          input int sh, input int db, input int lg,
                          input int r0, input int r1, input int r2,
                          input int bf, input int bt, input int len);
      logic [7:0] exp;
      for (int c = 0; c < len; c++) begin
         @(posedge clk);
         #1;
         exp = {3'b000, 1'(c == sh), 1'(c == db), 1'(c == lg),
                1'(c == r0 || c == r1 || c == r2), 1'(c >= bf && c < bt)};
         chk($sformatf("scn%0d_t%0d", id, c), outs(), exp);
         bif.btn_pedge = (c == p0 || c == p1);
         bif.btn_nedge = (c == n0 || c == n1);
      end
      @(posedge clk);
      #1;
      bif.btn_pedge = 1'b0;
      bif.btn_nedge = 1'b0;
   endtask

   initial begin
      n_cmp         = 0;
      n_bad         = 0;
      reset_p       = 1'b1;
      bif.btn_pedge = 1'b0;
      bif.btn_nedge = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("in_reset", outs(), 8'h00);
      reset_p = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("after_reset", outs(), 8'h00);

      // short click: release at 3, gap times out -> short_press at 3+9
      run_scn(1,  0, -1,  3, -1,  12, -1, -1,  -1, -1, -1,  1, 12, 16);
      // long hold: long at 0+21, repeats every 5, release at 40 -> idle at 41
      run_scn(2,  0, -1, 40, -1,  -1, -1, 21,  26, 31, 36,  1, 41, 44);
      // double click: second release at 9 -> double_click at 10, never short
      run_scn(3,  0,  6,  3,  9,  -1, 10, -1,  -1, -1, -1,  1, 10, 22);
      // lone release and simultaneous press+release in IDLE -> nothing
      run_scn(4,  2, -1,  0,  2,  -1, -1, -1,  -1, -1, -1, -1, -1,  8);
      // release lands on the long-timeout cycle (cnt==19 in cycle 20): edge wins
      run_scn(5,  0, -1, 20, -1,  29, -1, -1,  -1, -1, -1,  1, 29, 34);

      // reset asserted asynchronously while long-held
      @(posedge clk);
      #1;
      bif.btn_pedge = 1'b1;
      @(posedge clk);
      #1;
      bif.btn_pedge = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      chk("long_held_busy", {7'b0, bif.busy}, 8'h01);
      #2;
      reset_p = 1'b1;
      #1;
      chk("reset_mid_gesture", outs(), 8'h00);
      repeat (2) @(posedge clk);
      #1;
      reset_p = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post_reset_%0d", i), outs(), 8'h00);
      end

      // next gesture classifies normally after the abort
      run_scn(6,  0, -1,  3, -1,  12, -1, -1,  -1, -1, -1,  1, 12, 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
